pc_sequencer: RTL and testbench

- Program-counter / fetch sequencer. It is the consumer end of the branch-target lookup.
- Drives the 3-bit target-select code out to the PC target LUT, takes back the D-bit target, and computes next PC each cycle.
- Supports sequential increment, relative branch, absolute jump, stall, halt and restart.
- Sits between the instruction decoder/control and the instruction ROM address.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer: IDLE/RUN/HALTED control, PC increment, relative/absolute jumps.
// Optional taken-jump counter enabled by defining PC_SEQ_JUMP_COUNT_EN.
module pc_sequencer #(
    parameter int          D          = 12,
    parameter int unsigned START_ADDR = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic         stall,
    input  logic         halt_req,
    input  logic         jump_en,
    input  logic         abs_jump,
    input  logic [2:0]   jump_sel,
    output logic [2:0]   lut_sel,
    input  logic [D-1:0] lut_target,
    output logic [D-1:0] pc,
    output logic         running,
    output logic         done,
    output logic         flush,
    output logic [15:0]  jump_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    localparam logic [D-1:0] START_PC = D'(START_ADDR);

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic           flush_q, flush_d;
    logic           take_jump_s;
    logic           restart_s;

    // Next-state and next-PC selection; stall beats halt beats jump beats increment.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = 1'b0;
        take_jump_s = 1'b0;
        restart_s   = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d   = S_RUN;
                    pc_d      = START_PC;
                    restart_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (halt_req) begin
                    state_d = S_HALTED;
                end else if (jump_en) begin
                    take_jump_s = 1'b1;
                    flush_d     = 1'b1;
                    pc_d        = abs_jump ? lut_target : (pc_q + lut_target);
                end else begin
                    pc_d = pc_q + D'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = START_PC;
            end
        endcase
    end

    // State, PC and flush registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign lut_sel = jump_sel;
    assign pc      = pc_q;
    assign flush   = flush_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_HALTED);

`ifdef PC_SEQ_JUMP_COUNT_EN
    logic [15:0] jcnt_q, jcnt_d;

    // Saturating taken-jump count, cleared whenever execution restarts.
    always_comb begin
        jcnt_d = jcnt_q;
        if (restart_s) begin
            jcnt_d = 16'h0000;
        end else if (take_jump_s && (jcnt_q != 16'hFFFF)) begin
            jcnt_d = jcnt_q + 16'h0001;
        end else begin
            jcnt_d = jcnt_q;
        end
    end

    // Jump counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            jcnt_q <= 16'h0000;
        end else begin
            jcnt_q <= jcnt_d;
        end
    end

    assign jump_count = jcnt_q;
`else
    logic unused_jcnt_s;
    assign unused_jcnt_s = take_jump_s ^ restart_s;
    assign jump_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by randomized traffic,
// compared against a cycle-level behavioural model of the sequencer.
module tb_pc_sequencer;

    localparam int D     = 12;
    localparam int MODV  = 4096;
    localparam int START = 0;

    logic          Clk = 1'b0;
    logic          Reset, start, stall, halt_req, jump_en, abs_jump;
    logic [2:0]    jump_sel;
    logic [2:0]    lut_sel;
    logic [D-1:0]  lut_target;
    logic [D-1:0]  pc;
    logic          running, done, flush;
    logic [15:0]   jump_count;

    int checks   = 0;
    int failures = 0;

    // model: 0 idle, 1 run, 2 halted
    int m_mode  = 0;
    int m_pc    = 0;
    int m_flush = 0;
    int m_cnt   = 0;

`ifdef PC_SEQ_JUMP_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    pc_sequencer #(.D(D), .START_ADDR(START)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .stall      (stall),
        .halt_req   (halt_req),
        .jump_en    (jump_en),
        .abs_jump   (abs_jump),
        .jump_sel   (jump_sel),
        .lut_sel    (lut_sel),
        .lut_target (lut_target),
        .pc         (pc),
        .running    (running),
        .done       (done),
        .flush      (flush),
        .jump_count (jump_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit st, input bit sl, input bit h,
                         input bit je, input bit ab, input int tgt);
        Reset      = r;
        start      = st;
        stall      = sl;
        halt_req   = h;
        jump_en    = je;
        abs_jump   = ab;
        jump_sel   = 3'(tgt);
        lut_target = D'(tgt);
    endtask

    // Apply the driven inputs for one clock and check outputs against the model.
    task automatic step();
        int tgt;
        #1;
        chk("lut_sel", {29'd0, lut_sel}, {29'd0, jump_sel});
        tgt = int'(lut_target);
        m_flush = 0;
        if (Reset) begin
            m_mode = 0; m_pc = START; m_cnt = 0;
        end else if (m_mode == 1) begin
            if (stall) begin
                // frozen
            end else if (halt_req) begin
                m_mode = 2;
            end else if (jump_en) begin
                m_pc    = abs_jump ? tgt : (m_pc + tgt) % MODV;
                m_flush = 1;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_pc = (m_pc + 1) % MODV;
            end
        end else if (start) begin
            m_mode = 1; m_pc = START; m_cnt = 0;
        end
        @(posedge Clk);
        #1;
        chk("pc", {20'd0, pc}, 32'(m_pc));
        chk("running", {31'd0, running}, 32'(m_mode == 1));
        chk("done", {31'd0, done}, 32'(m_mode == 2));
        chk("flush", {31'd0, flush}, 32'(m_flush));
        chk("jump_count", {16'd0, jump_count}, CNT_EN ? 32'(m_cnt) : 32'd0);
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        step();
        chk("reset_pc", {20'd0, pc}, 32'd0);
        chk("reset_running", {31'd0, running}, 32'd0);

        // idle ignores everything but start
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 77);
        step();
        chk("idle_hold", {20'd0, pc}, 32'd0);

        // start, then plain increments 0..5
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("seq_pc5", {20'd0, pc}, 32'd5);

        // abs to 30, relative -26 -> 4, abs 184
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 30);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'hFE6);
        step();
        chk("rel_back", {20'd0, pc}, 32'd4);
        chk("rel_flush", {31'd0, flush}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 184);
        step();
        chk("abs_184", {20'd0, pc}, 32'd184);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("flush_one_cycle", {31'd0, flush}, 32'd0);

        // wrap-around on increment and on relative add
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 'hFFF);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("inc_wrap", {20'd0, pc}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 'hFF0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 22);
        step();
        chk("rel_wrap", {20'd0, pc}, 32'd6);

        // relative offset 0: pc holds, flush pulses
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step();
        chk("rel_zero", {20'd0, pc}, 32'd6);

        // stall beats jump for 3 cycles, then jump is taken
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 300);
        for (int i = 0; i < 3; i++) step();
        chk("stall_frozen", {20'd0, pc}, 32'd6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 300);
        step();
        chk("post_stall_jump", {20'd0, pc}, 32'd300);

        // halt beats jump at pc=50, start ignored while running
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 50);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 99);
        step();
        chk("halt_pc", {20'd0, pc}, 32'd50);
        chk("halt_done", {31'd0, done}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("restart_pc", {20'd0, pc}, 32'd0);

        // run to 9, reset mid-jump
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 500);
        step();
        chk("reset_mid_run", {20'd0, pc}, 32'd0);

        // jump counter: 3 taken, 1 stalled
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 40);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20);
        step();
        chk("jcnt_3", {16'd0, jump_count}, CNT_EN ? 32'd3 : 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("jcnt_clear", {16'd0, jump_count}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(99) == 0, $urandom_range(7) == 0,
                  $urandom_range(4) == 0, $urandom_range(29) == 0,
                  $urandom_range(2) == 0, $urandom_range(1) == 0,
                  int'($urandom_range(4095)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
